// File: rtl/psd_display_pkg.sv
// Shared types, glyphs and sizing helpers for the
// seven-segment scan driver.
package psd_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef struct packed {
        logic       dash;
        logic       blank;
        logic [3:0] val;
    } dcode_t;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } state_t;

    // ceil(w * log10(2)); w*log10(2) is never an integer for w >= 1
    function automatic int bcd_digits(input int w);
        return (w * 301030 + 999999) / 1000000;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            4'hF: g = 7'h0E;
        endcase
        return g;
    endfunction

    function automatic logic [6:0] seg_of(input dcode_t c);
        if (c.dash)
            return SEG_DASH;
        if (c.blank)
            return SEG_BLANK;
        return glyph(c.val);
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift-add-3 step per
// cycle, DATA_W steps after start, done pulses once.
module bin2bcd_seq
    import psd_display_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NBCD   = bcd_digits(DATA_W)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [DATA_W-1:0]   bin,
    output logic                done,
    output logic [4*NBCD-1:0]   bcd
);

    localparam int CW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] sh;
    logic [CW-1:0]     cnt;
    logic              run;
    logic [4*NBCD-1:0] adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < NBCD; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sh   <= '0;
            bcd  <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sh  <= bin;
                bcd <= '0;
                cnt <= CW'(DATA_W);
                run <= 1'b1;
            end else if (run) begin
                {bcd, sh} <= {adj[4*NBCD-2:0], sh, 1'b0};
                cnt       <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd7seg_scan_driver.sv
// Multi-digit common-anode seven-segment driver with
// decimal/hex conversion, blanking and overflow dashes.
module bcd7seg_scan_driver
    import psd_display_pkg::*;
#(
    parameter int DATA_W        = 16,
    parameter int DIGITS        = 5,
    parameter int REFRESH_DIV   = 100000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic              hex_mode,
    output logic              busy,
    output logic              overflow,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [DIGITS-1:0] an
);

    localparam int NBCD = bcd_digits(DATA_W);
    localparam int NS   = (NBCD > DIGITS) ? NBCD : DIGITS;
    localparam int PW   = $clog2(REFRESH_DIV);
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t                   state, nstate;
    logic [DATA_W-1:0]        data_q;
    logic                     hex_q;
    logic                     hex_done;
    logic                     bcd_done;
    logic [4*NBCD-1:0]        bcd;
    logic                     accept;
    logic [4*NS-1:0]          src;
    logic                     ovf_c;
    logic                     lead;
    dcode_t [DIGITS-1:0]      code;
    dcode_t [DIGITS-1:0]      disp;
    logic [PW-1:0]            pre;
    logic [IW-1:0]            idx, idx_n;
    logic                     tc;

    assign load_ready = (state == IDLE);
    assign busy       = !load_ready;
    assign accept     = load_valid && load_ready;
    assign dp         = 1'b1;

    bin2bcd_seq #(
        .DATA_W (DATA_W),
        .NBCD   (NBCD)
    ) u_b2b (
        .clock (clock),
        .reset (reset),
        .start (accept && !hex_mode),
        .bin   (load_data),
        .done  (bcd_done),
        .bcd   (bcd)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    if (accept) nstate = CONVERT;
            CONVERT: if (hex_q ? hex_done : bcd_done)
                         nstate = COMMIT;
            COMMIT:  nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_q   <= '0;
            hex_q    <= 1'b0;
            hex_done <= 1'b0;
        end else begin
            if (accept) begin
                data_q <= load_data;
                hex_q  <= hex_mode;
            end
            hex_done <= (state == CONVERT) && hex_q && !hex_done;
        end
    end

    // Digits are scanned from the top so blanking stops at
    // the first nonzero digit; overflow forces dashes.
    always_comb begin
        src   = hex_q ? (4*NS)'(data_q) : (4*NS)'(bcd);
        ovf_c = 1'b0;
        lead  = 1'b1;
        code  = '0;
        for (int i = DIGITS; i < NS; i++) begin
            if (src[4*i +: 4] != 4'd0)
                ovf_c = 1'b1;
        end
        for (int i = DIGITS - 1; i >= 0; i--) begin
            code[i].val  = src[4*i +: 4];
            code[i].dash = ovf_c;
            if (src[4*i +: 4] != 4'd0)
                lead = 1'b0;
            code[i].blank = BLANK_LEADING && lead
                            && (i != 0) && !ovf_c;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            for (int i = 0; i < DIGITS; i++)
                disp[i] <= {1'b0, BLANK_LEADING && (i != 0), 4'd0};
        end else if (state == COMMIT) begin
            overflow <= ovf_c;
            disp     <= code;
        end
    end

    assign tc = (pre == PW'(REFRESH_DIV - 1));

    always_comb begin
        idx_n = idx;
        if (tc)
            idx_n = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pre <= '0;
            idx <= '0;
            an  <= '1;
            seg <= SEG_BLANK;
        end else begin
            pre <= tc ? '0 : pre + 1'b1;
            idx <= idx_n;
            an  <= ~(DIGITS'(1) << idx_n);
            seg <= seg_of(disp[idx_n]);
        end
    end

endmodule

// File: tb/tb_bcd7seg_scan_driver.sv
// Bench for bcd7seg_scan_driver: vector table through a
// scoreboard, plus scan, busy-ignore and reset sequences.
module tb_bcd7seg_scan_driver;

    logic        clock = 1'b0;
    logic        reset;
    logic        v5, v4, hex;
    logic [15:0] data;

    logic        rdy5, busy5, ovf5, dp5;
    logic [6:0]  seg5;
    logic [4:0]  an5;
    logic        rdy4, busy4, ovf4, dp4;
    logic [6:0]  seg4;
    logic [3:0]  an4;

    always #5 clock = ~clock;

    bcd7seg_scan_driver #(
        .DATA_W(16), .DIGITS(5),
        .REFRESH_DIV(4), .BLANK_LEADING(1'b1)
    ) dut5 (
        .clock(clock), .reset(reset),
        .load_valid(v5), .load_ready(rdy5),
        .load_data(data), .hex_mode(hex),
        .busy(busy5), .overflow(ovf5),
        .seg(seg5), .dp(dp5), .an(an5)
    );

    bcd7seg_scan_driver #(
        .DATA_W(16), .DIGITS(4),
        .REFRESH_DIV(4), .BLANK_LEADING(1'b1)
    ) dut4 (
        .clock(clock), .reset(reset),
        .load_valid(v4), .load_ready(rdy4),
        .load_data(data), .hex_mode(hex),
        .busy(busy4), .overflow(ovf4),
        .seg(seg4), .dp(dp4), .an(an4)
    );

    int         cur;
    logic       m_ready, m_ovf;
    logic [6:0] m_seg;
    logic [4:0] m_an;

    always_comb begin
        m_ready = (cur == 1) ? rdy4 : rdy5;
        m_ovf   = (cur == 1) ? ovf4 : ovf5;
        m_seg   = (cur == 1) ? seg4 : seg5;
        m_an    = (cur == 1) ? {1'b1, an4} : an5;
    end

    typedef struct {
        int               sel;
        logic [15:0]      data;
        logic             hex;
        logic [4:0][6:0]  exp;
        logic             ovf;
        int               lat;
    } vec_t;

    vec_t       vecs[10];
    vec_t       sb[$];
    logic [6:0] got[5];
    int         n_tests = 0;
    int         n_fail  = 0;

    function automatic vec_t mk(input int s, input logic [15:0] d,
                                input logic h, input logic [34:0] e,
                                input logic o, input int l);
        vec_t v;
        v.sel = s; v.data = d; v.hex = h;
        v.exp = e; v.ovf = o; v.lat = l;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] g,
                         input logic [31:0] e);
        n_tests++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, g, e);
        end
    endtask

    task automatic start_load(input int sel, input logic [15:0] d,
                              input logic h);
        @(negedge clock);
        cur  = sel;
        data = d;
        hex  = h;
        if (sel == 1) v4 = 1'b1;
        else          v5 = 1'b1;
        @(posedge clock);
        #1;
        v5 = 1'b0;
        v4 = 1'b0;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!m_ready && cyc < 200) begin
            @(posedge clock);
            #1;
            cyc++;
        end
    endtask

    task automatic capture();
        int nd;
        nd = (cur == 1) ? 4 : 5;
        for (int d = 0; d < 5; d++) got[d] = 'x;
        repeat (2) @(negedge clock);
        for (int c = 0; c < nd * 4 + 8; c++) begin
            @(negedge clock);
            for (int d = 0; d < nd; d++)
                if (m_an == ~(5'b1 << d)) got[d] = m_seg;
        end
    endtask

    task automatic compare_digits(input vec_t e, input string tag);
        int nd;
        nd = (e.sel == 1) ? 4 : 5;
        check($sformatf("%s %0h overflow", tag, e.data), m_ovf, e.ovf);
        for (int d = 0; d < nd; d++)
            check($sformatf("%s %0h digit%0d", tag, e.data, d),
                  got[d], e.exp[d]);
    endtask

    task automatic run_vec(input vec_t v);
        int   lat;
        vec_t e;
        sb.push_back(v);
        start_load(v.sel, v.data, v.hex);
        wait_ready(lat);
        capture();
        e = sb.pop_front();
        check($sformatf("vec %0h latency", e.data), lat, e.lat);
        compare_digits(e, "vec");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int         cyc;
        int         k, last;
        logic [4:0] prev, ea;
        vec_t       e;

        vecs[0] = mk(0, 16'd12345, 0, {7'h79,7'h24,7'h30,7'h19,7'h12}, 0, 18);
        vecs[1] = mk(0, 16'd42,    0, {7'h7F,7'h7F,7'h7F,7'h19,7'h24}, 0, 18);
        vecs[2] = mk(0, 16'hBEEF,  1, {7'h7F,7'h03,7'h06,7'h06,7'h0E}, 0, 3);
        vecs[3] = mk(0, 16'd0,     0, {7'h7F,7'h7F,7'h7F,7'h7F,7'h40}, 0, 18);
        vecs[4] = mk(0, 16'd65535, 0, {7'h02,7'h12,7'h12,7'h30,7'h12}, 0, 18);
        vecs[5] = mk(0, 16'h00A0,  1, {7'h7F,7'h7F,7'h7F,7'h08,7'h40}, 0, 3);
        vecs[6] = mk(0, 16'd10000, 0, {7'h79,7'h40,7'h40,7'h40,7'h40}, 0, 18);
        vecs[7] = mk(1, 16'd10000, 0, {7'h7F,7'h3F,7'h3F,7'h3F,7'h3F}, 1, 18);
        vecs[8] = mk(1, 16'd9999,  0, {7'h7F,7'h10,7'h10,7'h10,7'h10}, 0, 18);
        vecs[9] = mk(1, 16'hFFFF,  1, {7'h7F,7'h0E,7'h0E,7'h0E,7'h0E}, 0, 3);

        reset = 1'b0;
        v5 = 1'b0; v4 = 1'b0;
        data = '0; hex = 1'b0; cur = 0;
        repeat (3) @(negedge clock);
        check("reset seg", seg5, 7'h7F);
        check("reset an", an5, 5'h1F);
        check("reset dp", dp5, 1'b1);
        check("reset ready", rdy5, 1'b1);
        check("reset busy", busy5, 1'b0);
        check("reset overflow", ovf5, 1'b0);
        check("reset an4", an4, 4'hF);

        reset = 1'b1;
        prev = an5;
        k = 0;
        last = 0;
        for (int c = 0; c < 40 && k < 7; c++) begin
            @(negedge clock);
            if (an5 !== prev) begin
                ea = ~(5'b1 << (k % 5));
                check($sformatf("scan an step%0d", k), an5, ea);
                check($sformatf("scan seg step%0d", k), seg5,
                      (k % 5 == 0) ? 7'h40 : 7'h7F);
                if (k >= 2)
                    check($sformatf("scan period step%0d", k),
                          c - last, 4);
                last = c;
                prev = an5;
                k++;
            end
        end
        check("scan steps seen", k, 7);

        for (int i = 0; i < 10; i++)
            run_vec(vecs[i]);

        // A second load while converting must be dropped.
        sb.push_back(vecs[0]);
        start_load(0, 16'd12345, 1'b0);
        cyc = 0;
        while (!rdy5 && cyc < 200) begin
            v5 = (cyc == 3);
            if (cyc == 3) data = 16'd777;
            if (an5 == 5'b11110)
                check("hold during convert", seg5, 7'h40);
            @(posedge clock);
            #1;
            cyc++;
        end
        v5 = 1'b0;
        check("busy-ignore latency", cyc, 18);
        capture();
        e = sb.pop_front();
        compare_digits(e, "busy-ignore");
        check("busy-ignore idle after", busy5, 1'b0);

        run_vec(vecs[7]);
        check("dut4 overflow before reset", ovf4, 1'b1);

        start_load(0, 16'd12345, 1'b0);
        repeat (4) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("mid-reset seg", seg5, 7'h7F);
        check("mid-reset an", an5, 5'h1F);
        check("mid-reset ready", rdy5, 1'b1);
        check("mid-reset busy", busy5, 1'b0);
        check("mid-reset dut4 overflow", ovf4, 1'b0);
        check("mid-reset dut4 seg", seg4, 7'h7F);
        @(negedge clock);
        reset = 1'b1;
        cur = 0;
        capture();
        e = mk(0, 16'd0, 0, {7'h7F,7'h7F,7'h7F,7'h7F,7'h40}, 0, 0);
        compare_digits(e, "after-reset");
        check("after-reset busy", busy5, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
